// File: rtl/magnitude_pkg.sv
// rtl/magnitude_pkg.sv - width constants and state encoding for the iterative magnitude engine.
package magnitude_pkg;
  localparam int N  = 7;
  localparam int R  = N + 2;
  localparam int S  = 2 * R;
  localparam int CW = $clog2(R);

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;
endpackage

// File: rtl/magnitude_isqrt_seq_if.sv
// rtl/magnitude_isqrt_seq_if.sv - component input and magnitude output handshakes.
interface magnitude_isqrt_seq_if;
  logic [magnitude_pkg::N:0]   InputReal;
  logic [magnitude_pkg::N:0]   InputImaginary;
  logic                        InValid;
  logic                        InReady;
  logic [magnitude_pkg::R-1:0] OutMagnitude;
  logic                        OutValid;
  logic                        OutReady;

  modport master (output InputReal, InputImaginary, InValid, OutReady,
                  input  InReady, OutMagnitude, OutValid);
  modport slave  (input  InputReal, InputImaginary, InValid, OutReady,
                  output InReady, OutMagnitude, OutValid);
endinterface

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one restoring square-root iteration: bring down two radicand bits, resolve one root bit.
module isqrt_step
  import magnitude_pkg::*;
(
  input  logic [S-1:0] rem_i,
  input  logic [R-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [S-1:0] rem_o,
  output logic [R-1:0] root_o
);
  logic [S-1:0] rem_shift;
  logic [S-1:0] trial;
  logic         take;

  // The remainder never exceeds 2*root, so its top two bits are always zero here.
  assign rem_shift = {rem_i[S-3:0], bits_i};
  assign trial     = {{(S-R-2){1'b0}}, root_i, 2'b01};
  assign take      = (rem_shift >= trial);
  assign rem_o     = take ? (rem_shift - trial) : rem_shift;
  assign root_o    = {root_i[R-2:0], take};
endmodule

// File: rtl/magnitude_isqrt_seq.sv
// rtl/magnitude_isqrt_seq.sv - exact floor(sqrt(re^2+im^2)), one root bit per clock.
// MAGNITUDE_ROUND_EN: round the result to nearest instead of floor.
module magnitude_isqrt_seq
  import magnitude_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  magnitude_isqrt_seq_if.slave bus
);
  state_t        state_q, state_d;
  logic [N:0]    re_q, re_d;
  logic [N:0]    im_q, im_d;
  logic [S-1:0]  rad_q, rad_d;
  logic [S-1:0]  rem_q, rem_d;
  logic [R-1:0]  root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [R-1:0]  mag_q, mag_d;

  logic [S-1:0]  re_ext, im_ext;
  logic [S-1:0]  step_rem;
  logic [R-1:0]  step_root;

  assign re_ext = {{(S-N-1){1'b0}}, re_q};
  assign im_ext = {{(S-N-1){1'b0}}, im_q};

  isqrt_step u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[{cnt_q, 1'b0} +: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    state_d = state_q;
    re_d    = re_q;
    im_d    = im_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          re_d    = bus.InputReal;
          im_d    = bus.InputImaginary;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        rad_d   = re_ext * re_ext + im_ext * im_ext;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = CW'(R - 1);
        state_d = ROOT;
      end
      ROOT: begin
        rem_d  = step_rem;
        root_d = step_root;
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef MAGNITUDE_ROUND_EN
          // A remainder above the root means sqrt lies at or beyond root + 0.5.
          mag_d = (step_rem > {{(S-R){1'b0}}, step_root}) ? step_root + R'(1) : step_root;
`else
          mag_d = step_root;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      re_q    <= '0;
      im_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      re_q    <= re_d;
      im_q    <= im_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
    end
  end

  assign bus.InReady      = (state_q == IDLE);
  assign bus.OutValid     = (state_q == DONE);
  assign bus.OutMagnitude = mag_q;
endmodule
